// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Hazard controller for the 5-stage pipeline. It detects load-use
//   dependences that forwarding cannot cover and holds the front end for
//   MEM_LAT cycles. A taken branch in EX flushes the wrong-path
//   instruction in IF/ID and bubbles ID/EX.
//
// Parameters
//   MEM_LAT : load latency beyond EX, which is also the number of stall
//             cycles per load-use hazard (1..2**CNT_W-1)
//   CNT_W   : width of the internal stall counter
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   IF_ID__RS1/RS2        source registers of the instruction in ID
//   IF_ID__USE_RS1/RS2    ID instruction actually reads rs1/rs2
//   ID_EX__RD             destination register of the instruction in EX
//   ID_EX__MEM_READ       EX instruction is a load
//   EX__BRANCH_TAKEN      branch/jump in EX resolved taken
//   PC_WRITE              PC may update
//   IF_ID_WRITE           IF/ID may load
//   IF_ID_FLUSH           IF/ID loads a NOP
//   ID_EX_BUBBLE          ID/EX control fields zeroed
//   STALL                 front end held this cycle
//
// Optional build macro HAZARD_PERF_CNT_EN adds two saturating 32-bit
// counters: STALL_CYCLES (cycles with STALL=1) and FLUSH_EVENTS (cycles
// with IF_ID_FLUSH=1). Neither counter counts while in reset.

module hazard_stall_unit #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  IF_ID__RS1,
  input  logic [4:0]  IF_ID__RS2,
  input  logic        IF_ID__USE_RS1,
  input  logic        IF_ID__USE_RS2,
  input  logic [4:0]  ID_EX__RD,
  input  logic        ID_EX__MEM_READ,
  input  logic        EX__BRANCH_TAKEN,
  output logic        PC_WRITE,
  output logic        IF_ID_WRITE,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_BUBBLE,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] STALL_CYCLES,
  output logic [31:0] FLUSH_EVENTS,
`endif
  output logic        STALL
);

  if (MEM_LAT < 1 || MEM_LAT >= (2 ** CNT_W)) begin : g_bad_mem_lat
    $error("hazard_stall_unit: MEM_LAT=%0d out of range for CNT_W=%0d", MEM_LAT, CNT_W);
  end

  typedef enum logic {
    RUN,
    LOAD_WAIT
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               hz;

  // x0 never produces a hazard; a cleared USE bit masks its comparison.
  assign hz = ID_EX__MEM_READ && (ID_EX__RD != 5'd0) &&
              ((IF_ID__USE_RS1 && (IF_ID__RS1 == ID_EX__RD)) ||
               (IF_ID__USE_RS2 && (IF_ID__RS2 == ID_EX__RD)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    PC_WRITE     = 1'b1;
    IF_ID_WRITE  = 1'b1;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_BUBBLE = 1'b0;
    STALL        = 1'b0;

    unique case (state)
      RUN: begin
        if (EX__BRANCH_TAKEN) begin
          // The ID instruction is wrong-path, so any hazard it shows is moot.
          IF_ID_FLUSH  = 1'b1;
          ID_EX_BUBBLE = 1'b1;
        end else if (hz) begin
          PC_WRITE     = 1'b0;
          IF_ID_WRITE  = 1'b0;
          ID_EX_BUBBLE = 1'b1;
          STALL        = 1'b1;
          // With one cycle of latency the bubble in EX clears hz by itself;
          // longer latencies count down the remaining stall cycles.
          if (MEM_LAT > 1) begin
            state_nxt = LOAD_WAIT;
            cnt_nxt   = CNT_W'(MEM_LAT - 1);
          end
        end
      end
      LOAD_WAIT: begin
        PC_WRITE     = 1'b0;
        IF_ID_WRITE  = 1'b0;
        ID_EX_BUBBLE = 1'b1;
        STALL        = 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase

    if (rst_i) begin
      PC_WRITE     = 1'b0;
      IF_ID_WRITE  = 1'b0;
      IF_ID_FLUSH  = 1'b1;
      ID_EX_BUBBLE = 1'b1;
      STALL        = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      STALL_CYCLES <= '0;
      FLUSH_EVENTS <= '0;
    end else begin
      if (STALL && (STALL_CYCLES != '1))
        STALL_CYCLES <= STALL_CYCLES + 32'd1;
      if (IF_ID_FLUSH && (FLUSH_EVENTS != '1))
        FLUSH_EVENTS <= FLUSH_EVENTS + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Testbench for hazard_stall_unit. Three instances (MEM_LAT = 1, 3, 4)
// share one set of inputs; each is checked against a reference model that
// tracks the number of remaining stall cycles per instance.
// Output vectors are packed as {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH,
// ID_EX_BUBBLE, STALL}.

module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       use1 = 1'b0, use2 = 1'b0, mem_read = 1'b0, br = 1'b0;

  logic       pc_write [3];
  logic       if_id_write [3];
  logic       if_id_flush [3];
  logic       id_ex_bubble [3];
  logic       stall [3];
  logic [4:0] obs [3];
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles [3];
  logic [31:0] flush_events [3];
`endif

  int checks = 0;
  int errors = 0;
  int lat [3] = '{1, 3, 4};
  int rem [3] = '{0, 0, 0};

  localparam logic [4:0] V_RESET  = 5'b00111;
  localparam logic [4:0] V_STALL  = 5'b00011;
  localparam logic [4:0] V_BRANCH = 5'b11110;
  localparam logic [4:0] V_PASS   = 5'b11000;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MEM_LAT(1), .CNT_W(4)) u_l1 (
    .clk_i(clk), .rst_i(rst),
    .IF_ID__RS1(rs1), .IF_ID__RS2(rs2),
    .IF_ID__USE_RS1(use1), .IF_ID__USE_RS2(use2),
    .ID_EX__RD(rd), .ID_EX__MEM_READ(mem_read), .EX__BRANCH_TAKEN(br),
    .PC_WRITE(pc_write[0]), .IF_ID_WRITE(if_id_write[0]),
    .IF_ID_FLUSH(if_id_flush[0]), .ID_EX_BUBBLE(id_ex_bubble[0]),
`ifdef HAZARD_PERF_CNT_EN
    .STALL_CYCLES(stall_cycles[0]), .FLUSH_EVENTS(flush_events[0]),
`endif
    .STALL(stall[0])
  );

  hazard_stall_unit #(.MEM_LAT(3), .CNT_W(4)) u_l3 (
    .clk_i(clk), .rst_i(rst),
    .IF_ID__RS1(rs1), .IF_ID__RS2(rs2),
    .IF_ID__USE_RS1(use1), .IF_ID__USE_RS2(use2),
    .ID_EX__RD(rd), .ID_EX__MEM_READ(mem_read), .EX__BRANCH_TAKEN(br),
    .PC_WRITE(pc_write[1]), .IF_ID_WRITE(if_id_write[1]),
    .IF_ID_FLUSH(if_id_flush[1]), .ID_EX_BUBBLE(id_ex_bubble[1]),
`ifdef HAZARD_PERF_CNT_EN
    .STALL_CYCLES(stall_cycles[1]), .FLUSH_EVENTS(flush_events[1]),
`endif
    .STALL(stall[1])
  );

  hazard_stall_unit #(.MEM_LAT(4), .CNT_W(4)) u_l4 (
    .clk_i(clk), .rst_i(rst),
    .IF_ID__RS1(rs1), .IF_ID__RS2(rs2),
    .IF_ID__USE_RS1(use1), .IF_ID__USE_RS2(use2),
    .ID_EX__RD(rd), .ID_EX__MEM_READ(mem_read), .EX__BRANCH_TAKEN(br),
    .PC_WRITE(pc_write[2]), .IF_ID_WRITE(if_id_write[2]),
    .IF_ID_FLUSH(if_id_flush[2]), .ID_EX_BUBBLE(id_ex_bubble[2]),
`ifdef HAZARD_PERF_CNT_EN
    .STALL_CYCLES(stall_cycles[2]), .FLUSH_EVENTS(flush_events[2]),
`endif
    .STALL(stall[2])
  );

  for (genvar g = 0; g < 3; g++) begin : g_obs
    assign obs[g] = {pc_write[g], if_id_write[g], if_id_flush[g],
                     id_ex_bubble[g], stall[g]};
  end

  // ---------------- reference model ----------------
  function automatic bit hz_f();
    return mem_read && (rd != 0) &&
           ((use1 && rs1 == rd) || (use2 && rs2 == rd));
  endfunction

  function automatic logic [4:0] exp_vec(input int k);
    if (rst)         return V_RESET;
    if (rem[k] > 0)  return V_STALL;
    if (br)          return V_BRANCH;
    if (hz_f())      return V_STALL;
    return V_PASS;
  endfunction

  // rem[k] = stall cycles still owed after the current one.
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst)              rem[k] <= 0;
      else if (rem[k] > 0)  rem[k] <= rem[k] - 1;
      else if (!br && hz_f()) rem[k] <= lat[k] - 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic m, input logic [4:0] d, s1, s2,
                        input logic a1, a2, b);
    mem_read = m; rd = d; rs1 = s1; rs2 = s2; use1 = a1; use2 = a2; br = b;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // Hazard and branch inputs must not leak through while reset is held.
    set_in(1, 5, 5, 0, 1, 0, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== V_RESET) begin
          errors++;
          $display("FAIL reset_hold L=%0d cyc=%0d got=%b exp=%b", lat[k], c, obs[k], V_RESET);
        end
      end
    end
    next_cycle();
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== V_PASS) begin
        errors++;
        $display("FAIL reset_release L=%0d got=%b exp=%b", lat[k], obs[k], V_PASS);
      end
    end
    // Asynchronous assertion mid-cycle must take effect before any edge.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== V_RESET) begin
        errors++;
        $display("FAIL reset_async L=%0d got=%b exp=%b", lat[k], obs[k], V_RESET);
      end
    end
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    int scnt [3] = '{0, 0, 0};
    for (int c = 0; c < 6; c++) begin
      if (c == 0) set_in(1, 5, 5, 0, 1, 0, 0);
      else        set_in(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        scnt[k] += int'(stall[k]);
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL load_use L=%0d cyc=%0d got=%b exp=%b", lat[k], c, obs[k], exp_vec(k));
        end
      end
      next_cycle();
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (scnt[k] !== lat[k]) begin
        errors++;
        $display("FAIL load_use_len L=%0d got=%0d exp=%0d", lat[k], scnt[k], lat[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int scnt [3] = '{0, 0, 0};
    for (int c = 0; c < 12; c++) begin
      if (c < 6) set_in(1, 12, 3, 12, 0, 1, 0);
      else       set_in(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (c < 6) scnt[k] += int'(stall[k]);
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL back_to_back L=%0d cyc=%0d got=%b exp=%b", lat[k], c, obs[k], exp_vec(k));
        end
      end
      next_cycle();
    end
    // Holding the hazard must give an unbroken stall.
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (scnt[k] !== 6) begin
        errors++;
        $display("FAIL back_to_back_gap L=%0d got=%0d exp=6", lat[k], scnt[k]);
      end
    end
  endtask

  task automatic test_masking();
    for (int p = 0; p < 4; p++) begin
      case (p)
        0: set_in(1, 0, 0, 0, 1, 1, 0);   // x0 destination
        1: set_in(1, 7, 1, 7, 1, 0, 0);   // rs2 matches but unused
        2: set_in(0, 9, 9, 9, 1, 1, 0);   // not a load
        default: set_in(1, 7, 7, 2, 0, 0, 0); // rs1 matches but unused
      endcase
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== V_PASS || exp_vec(k) !== V_PASS) begin
          errors++;
          $display("FAIL masking L=%0d pat=%0d got=%b exp=%b", lat[k], p, obs[k], V_PASS);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_branch();
    set_in(1, 5, 5, 0, 1, 0, 1);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== V_BRANCH) begin
        errors++;
        $display("FAIL branch_prio L=%0d got=%b exp=%b", lat[k], obs[k], V_BRANCH);
      end
    end
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== V_PASS) begin
        errors++;
        $display("FAIL branch_no_wait L=%0d got=%b exp=%b", lat[k], obs[k], V_PASS);
      end
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_stall();
    set_in(1, 5, 5, 0, 1, 0, 0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    // MEM_LAT=4 instance is now in its second LOAD_WAIT cycle.
    @(negedge clk);
    checks++;
    if (obs[2] !== V_STALL) begin
      errors++;
      $display("FAIL mid_stall_pre got=%b exp=%b", obs[2], V_STALL);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (obs[2] !== V_RESET) begin
      errors++;
      $display("FAIL mid_stall_rst got=%b exp=%b", obs[2], V_RESET);
    end
    next_cycle();
    rst = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cycles[2] !== 32'd0 || flush_events[2] !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset got=%0d/%0d exp=0/0", stall_cycles[2], flush_events[2]);
    end
`endif
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== V_PASS) begin
          errors++;
          $display("FAIL mid_stall_after L=%0d cyc=%0d got=%b exp=%b", lat[k], c, obs[k], V_PASS);
        end
      end
      next_cycle();
    end
`ifdef HAZARD_PERF_CNT_EN
    set_in(1, 5, 5, 0, 1, 0, 0);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    repeat (3) next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 1);
    next_cycle();
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (stall_cycles[2] !== 32'd4 || flush_events[2] !== 32'd1) begin
      errors++;
      $display("FAIL perf_count got=%0d/%0d exp=4/1", stall_cycles[2], flush_events[2]);
    end
    next_cycle();
`endif
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic b;
      b = ($urandom_range(0, 5) == 0);
      // A taken branch while EX holds a bubble is a protocol violation.
      if (rem[0] > 0 || rem[1] > 0 || rem[2] > 0) b = 1'b0;
      set_in(logic'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), b);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++;
          $display("FAIL random L=%0d cyc=%0d got=%b exp=%b", lat[k], c, obs[k], exp_vec(k));
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_back_to_back();
    test_masking();
    test_branch();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
